// File: rtl/tc_bank.sv
// tc_bank: bank of NUM_CH independent down-counting timer channels with a
// small register file per channel (CTRL, PRESET, COUNT, STATUS).
//
// Channel FSM
//   state  | meaning
//   S_IDLE | stopped, waiting for EN=1
//   S_LOAD | copying PRESET into COUNT
//   S_CNT  | decrementing COUNT until it reaches zero
//   S_INT  | raising PEND, then reloading (MODE=01) or stopping (one-shot)
module tc_bank #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [29:0]       Addr,
  input  logic              WE,
  input  logic [31:0]       Din,
  output logic [31:0]       Dout,
  output logic [NUM_CH-1:0] IRQ
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;

  logic [2:0]  w_ch_sel;
  logic [1:0]  w_reg_sel;
  logic [31:0] w_rd_data [8];
  logic        w_unused_bits;

  assign w_ch_sel  = Addr[4:2];
  assign w_reg_sel = Addr[1:0];

  // Upper address bits carry no meaning; Din bits above CNT_W are dropped.
  assign w_unused_bits = &{1'b0, Addr[29:5], Din};

  // Unimplemented channel slots read as zero, so an out-of-range index needs
  // no extra decode on the read path.
  for (genvar gi = 0; gi < 8; gi++) begin : g_ch
    if (gi < NUM_CH) begin : g_on
      localparam logic [2:0] CH_IDX = 3'(gi);

      state_t           r_state, w_state_nxt;
      logic             r_en, r_im, r_pend;
      logic [1:0]       r_mode;
      logic [CNT_W-1:0] r_preset, r_count, w_count_nxt;
      logic             w_pend_set, w_en_clr;
      logic             w_hit, w_wr_ctrl, w_wr_preset, w_wr_status;

      assign w_hit       = WE && (w_ch_sel == CH_IDX);
      assign w_wr_ctrl   = w_hit && (w_reg_sel == 2'd0);
      assign w_wr_preset = w_hit && (w_reg_sel == 2'd1);
      assign w_wr_status = w_hit && (w_reg_sel == 2'd3);

      // Next-state, next-count and the hardware PEND-set / EN-clear strobes.
      always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_pend_set  = 1'b0;
        w_en_clr    = 1'b0;
        if (!r_en) begin
          w_state_nxt = S_IDLE;
        end else begin
          case (r_state)
            S_IDLE: w_state_nxt = S_LOAD;
            S_LOAD: begin
              w_count_nxt = r_preset;
              w_state_nxt = S_CNT;
            end
            S_CNT: begin
              if (r_count == '0) w_state_nxt = S_INT;
              else               w_count_nxt = r_count - CNT_W'(1);
            end
            S_INT: begin
              w_pend_set = 1'b1;
              if (r_mode == 2'b01) begin
                w_state_nxt = S_LOAD;
              end else begin
                w_en_clr    = 1'b1;
                w_state_nxt = S_IDLE;
              end
            end
            default: w_state_nxt = S_IDLE;
          endcase
        end
      end

      // FSM state and counter registers.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_state <= S_IDLE;
          r_count <= '0;
        end else begin
          r_state <= w_state_nxt;
          r_count <= w_count_nxt;
        end
      end

      // CPU-visible registers; a CPU CTRL write beats the one-shot EN clear,
      // while a hardware PEND set beats a CPU STATUS clear.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_en     <= 1'b0;
          r_mode   <= 2'b00;
          r_im     <= 1'b0;
          r_preset <= '0;
          r_pend   <= 1'b0;
        end else begin
          if (w_wr_ctrl) begin
            r_en   <= Din[0];
            r_mode <= Din[2:1];
            r_im   <= Din[3];
          end else if (w_en_clr) begin
            r_en <= 1'b0;
          end
          if (w_wr_preset) r_preset <= Din[CNT_W-1:0];
          if (w_pend_set)                      r_pend <= 1'b1;
          else if (w_wr_status && Din[0])      r_pend <= 1'b0;
        end
      end

      assign w_rd_data[gi] = (w_reg_sel == 2'd0) ? 32'({r_im, r_mode, r_en}) :
                             (w_reg_sel == 2'd1) ? 32'(r_preset) :
                             (w_reg_sel == 2'd2) ? 32'(r_count)  :
                                                   32'(r_pend);
      assign IRQ[gi] = r_pend & r_im;
    end else begin : g_off
      assign w_rd_data[gi] = '0;
    end
  end

  assign Dout = w_rd_data[w_ch_sel];

endmodule

// File: tb/tb_tc_bank.sv
// Bench for tc_bank: a timeline model (phase start edge + latched preset)
// predicts IRQ and read data every cycle; directed tests pin key edges.
module tb_tc_bank;
  localparam int NUM_CH = 2;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [29:0]       Addr = '0;
  logic              WE = 1'b0;
  logic [31:0]       Din = '0;
  logic [31:0]       Dout;
  logic [NUM_CH-1:0] IRQ;

  tc_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .Addr(Addr), .WE(WE), .Din(Din),
    .Dout(Dout), .IRQ(IRQ)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Model: per channel, registers plus a timeline. A phase starts at edge S
  // (leaving idle); PRESET is latched at S+1 and counts down from there;
  // PEND is raised at S+lp+3, where auto-reload starts the next phase.
  int m_en[NUM_CH], m_mode[NUM_CH], m_im[NUM_CH], m_preset[NUM_CH];
  int m_pend[NUM_CH], m_act[NUM_CH], m_s[NUM_CH], m_lp[NUM_CH], m_hold[NUM_CH];
  int set_p[NUM_CH], clr_e[NUM_CH];
  int t = 0;

  function automatic int cnt_at(int ch, int tt);
    int d;
    if (m_act[ch] == 0 || tt < m_s[ch] + 1) return m_hold[ch];
    d = tt - m_s[ch] - 1;
    return (d >= m_lp[ch]) ? 0 : m_lp[ch] - d;
  endfunction

  function automatic logic [31:0] m_read(logic [29:0] a);
    int ch;
    ch = int'(a[4:2]);
    if (ch >= NUM_CH) return 32'd0;
    case (a[1:0])
      2'd0:    return 32'(m_im[ch] * 8 + m_mode[ch] * 2 + m_en[ch]);
      2'd1:    return 32'(m_preset[ch]);
      2'd2:    return 32'(cnt_at(ch, t));
      default: return 32'(m_pend[ch]);
    endcase
  endfunction

  function automatic logic [NUM_CH-1:0] m_irq();
    logic [NUM_CH-1:0] v;
    for (int c = 0; c < NUM_CH; c++) v[c] = (m_pend[c] != 0 && m_im[c] != 0);
    return v;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_en[c] = 0; m_mode[c] = 0; m_im[c] = 0; m_preset[c] = 0;
        m_pend[c] = 0; m_act[c] = 0; m_hold[c] = 0;
      end
    end else begin
      t = t + 1;
      for (int c = 0; c < NUM_CH; c++) begin
        set_p[c] = 0;
        clr_e[c] = 0;
        if (m_en[c] == 0) begin
          if (m_act[c] != 0) begin
            m_hold[c] = cnt_at(c, t - 1);
            m_act[c] = 0;
          end
        end else if (m_act[c] == 0) begin
          m_act[c] = 1;
          m_s[c] = t;
        end else if (t == m_s[c] + 1) begin
          m_lp[c] = m_preset[c];
        end else if (t == m_s[c] + m_lp[c] + 3) begin
          set_p[c] = 1;
          m_hold[c] = 0;
          if (m_mode[c] == 1) m_s[c] = t;
          else begin
            m_en[c] = 0;
            m_act[c] = 0;
          end
        end
      end
      if (WE && int'(Addr[4:2]) < NUM_CH) begin
        case (Addr[1:0])
          2'd0: begin
            m_en[Addr[4:2]] = int'(Din[0]);
            m_mode[Addr[4:2]] = int'(Din[2:1]);
            m_im[Addr[4:2]] = int'(Din[3]);
          end
          2'd1: m_preset[Addr[4:2]] = int'(Din[15:0]);
          2'd3: if (Din[0]) m_pend[Addr[4:2]] = 0;
          default: ;
        endcase
      end
      for (int c = 0; c < NUM_CH; c++) if (set_p[c] != 0) m_pend[c] = 1;
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      chk("irq_cycle", 32'(IRQ), 32'(m_irq()));
      chk("dout_cycle", Dout, m_read(Addr));
    end
  end

  task automatic wr(int ch, int r, logic [31:0] d);
    @(posedge clk); #1;
    Addr = 30'(ch * 4 + r);
    WE = 1'b1;
    Din = d;
    @(posedge clk); #1;
    WE = 1'b0;
  endtask

  task automatic rd(string nm, int ch, int r, logic [31:0] exp);
    Addr = 30'(ch * 4 + r);
    #1;
    chk(nm, Dout, exp);
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    chk("reset_irq", 32'(IRQ), 32'd0);
    chk("reset_dout", Dout, 32'd0);
    #10 reset = 1'b0;

    // One-shot ch0, PRESET=5: IRQ after edge 9, EN self-clears.
    wr(0, 1, 5);
    wr(0, 0, 32'h9);
    step(8);  chk("oneshot_early", 32'(IRQ[0]), 32'd0);
    step(1);  chk("oneshot_irq", 32'(IRQ[0]), 32'd1);
    rd("oneshot_ctrl", 0, 0, 32'h8);
    rd("oneshot_count", 0, 2, 32'd0);
    wr(0, 3, 1);
    chk("oneshot_clr", 32'(IRQ[0]), 32'd0);

    // Auto-reload ch1, PRESET=3: PEND every 6 cycles.
    wr(1, 1, 3);
    wr(1, 0, 32'hB);
    step(6);  chk("auto_early", 32'(IRQ[1]), 32'd0);
    step(1);  chk("auto_first", 32'(IRQ[1]), 32'd1);
    wr(1, 3, 1);
    chk("auto_cleared", 32'(IRQ[1]), 32'd0);
    step(3);  chk("auto_gap", 32'(IRQ[1]), 32'd0);
    step(1);  chk("auto_second", 32'(IRQ[1]), 32'd1);
    wr(1, 1, 32'h1234_0002);
    rd("preset_trunc", 1, 1, 32'd2);

    // Masked expiry, then clear-vs-set race.
    wr(0, 1, 2);
    wr(0, 0, 32'h1);
    step(6);  chk("masked_irq", 32'(IRQ[0]), 32'd0);
    rd("masked_pend", 0, 3, 32'd1);
    wr(0, 3, 1);
    wr(0, 0, 32'h9);
    step(4);
    wr(0, 3, 1);
    rd("race_pend", 0, 3, 32'd1);
    chk("race_irq", 32'(IRQ[0]), 32'd1);

    // CPU CTRL write on the one-shot EN-clear edge wins.
    wr(0, 3, 1);
    wr(0, 0, 32'h9);
    step(4);
    wr(0, 0, 32'h9);
    rd("ctrl_race", 0, 0, 32'h9);
    wr(0, 0, 32'h0);
    wr(0, 3, 1);

    // PRESET=0: INT right after LOAD, PEND after edge 4.
    wr(0, 1, 0);
    wr(0, 0, 32'h9);
    step(3);  chk("zero_early", 32'(IRQ[0]), 32'd0);
    step(1);  chk("zero_irq", 32'(IRQ[0]), 32'd1);
    rd("zero_count", 0, 2, 32'd0);
    wr(0, 3, 1);

    // Disable at COUNT=40, then re-enable reloads 100.
    wr(0, 1, 100);
    wr(0, 0, 32'h1);
    step(60);
    wr(0, 0, 32'h0);
    step(3);
    rd("dis_count", 0, 2, 32'd40);
    chk("dis_irq", 32'(IRQ[0]), 32'd0);
    wr(0, 0, 32'h1);
    step(2);
    rd("reload_count", 0, 2, 32'd100);
    wr(0, 0, 32'h0);

    // Out-of-range channel and aliased upper address bits.
    wr(7, 0, 32'hF);
    wr(7, 1, 32'h55);
    wr(7, 3, 1);
    rd("ch7_ctrl", 7, 0, 32'd0);
    rd("ch7_preset", 7, 1, 32'd0);
    step(1);
    rd("ch0_untouched", 0, 0, 32'd0);
    rd("alias_preset", 9, 1, 32'd2);

    // Async reset mid-count.
    wr(0, 1, 50);
    wr(0, 0, 32'h9);
    step(10);
    chk("pre_rst_irq1", 32'(IRQ[1]), 32'd1);
    #1 reset = 1'b1;
    #1 chk("rst_irq", 32'(IRQ), 32'd0);
    rd("rst_count", 0, 2, 32'd0);
    rd("rst_ctrl1", 1, 0, 32'd0);
    step(2);
    reset = 1'b0;
    step(60);
    chk("post_rst_irq", 32'(IRQ), 32'd0);
    rd("post_rst_ctrl", 0, 0, 32'd0);
    wr(0, 1, 1);
    wr(0, 0, 32'h9);
    step(4);  chk("reen_early", 32'(IRQ[0]), 32'd0);
    step(1);  chk("reen_irq", 32'(IRQ[0]), 32'd1);
    step(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
